// File: rtl/aes128_pkg.sv
// Shared AES-128 decryption helpers: byte/state types, inverse-round FSM states,
// GF(2^8) constant multiplies, InvShiftRows and InvMixColumns.
package aes128_pkg;

    typedef logic [7:0] aes_byte_t;

    // Byte k of a state sits at element 15-k, so the packed vector reads MSB-first.
    typedef logic [15:0][7:0] aes_state_t;

    typedef enum logic [1:0] {
        IDLE,
        SUB,
        MIX,
        DONE
    } inv_round_state_t;

    function automatic aes_byte_t xtime(input aes_byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic aes_byte_t gf_mul09(input aes_byte_t b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic aes_byte_t gf_mul0b(input aes_byte_t b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic aes_byte_t gf_mul0d(input aes_byte_t b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic aes_byte_t gf_mul0e(input aes_byte_t b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

    // Row r rotates right by r: output (r,c) takes input (r,(c-r) mod 4).
    function automatic aes_state_t inv_shift_rows(input aes_state_t s);
        aes_state_t o;
        o = s;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                o[4'(15 - (r + 4 * c))] = s[4'(15 - (r + 4 * ((c - r + 4) % 4)))];
            end
        end
        return o;
    endfunction

    function automatic aes_state_t inv_mix_columns(input aes_state_t s);
        aes_state_t o;
        aes_byte_t  a0, a1, a2, a3;
        o = s;
        for (int c = 0; c < 4; c++) begin
            a0 = s[4'(15 - 4 * c)];
            a1 = s[4'(14 - 4 * c)];
            a2 = s[4'(13 - 4 * c)];
            a3 = s[4'(12 - 4 * c)];
            o[4'(15 - 4 * c)] = gf_mul0e(a0) ^ gf_mul0b(a1) ^ gf_mul0d(a2) ^ gf_mul09(a3);
            o[4'(14 - 4 * c)] = gf_mul09(a0) ^ gf_mul0e(a1) ^ gf_mul0b(a2) ^ gf_mul0d(a3);
            o[4'(13 - 4 * c)] = gf_mul0d(a0) ^ gf_mul09(a1) ^ gf_mul0e(a2) ^ gf_mul0b(a3);
            o[4'(12 - 4 * c)] = gf_mul0b(a0) ^ gf_mul0d(a1) ^ gf_mul09(a2) ^ gf_mul0e(a3);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes128_rijndael_inv_sbox.sv
// Combinational Rijndael inverse S-box: full 256-entry lookup, byte in, byte out.
module aes128_rijndael_inv_sbox
    import aes128_pkg::*;
(
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    localparam aes_byte_t INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    always_comb begin
        out_byte = INV_SBOX[in_byte];
    end

endmodule

// File: rtl/aes128_inv_round.sv
// One AES-128 inverse round, S-box shared across bytes over several SUB cycles.
// Define AES128_INV_ROUND_PAR4_EN for four S-boxes (one column per cycle).
module aes128_inv_round
    import aes128_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_i,
    input  logic [127:0] state_i,
    input  logic [127:0] round_key_i,
    input  logic         last_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [127:0] state_o
);

`ifdef AES128_INV_ROUND_PAR4_EN
    localparam int LANES = 4;
    localparam int CNT_W = 2;
`else
    localparam int LANES = 1;
    localparam int CNT_W = 4;
`endif

    inv_round_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    aes_state_t       work_q, work_sub, key_q, mixed;
    logic             last_q;
    logic             last_group;
    aes_byte_t        sbox_in  [LANES];
    aes_byte_t        sbox_out [LANES];
    logic [3:0]       lane_idx [LANES];

    assign last_group = (cnt_q == {CNT_W{1'b1}});

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = SUB;
            SUB:     if (last_group) state_d = MIX;
            MIX:     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o = (state_q != IDLE);
        done_o = (state_q == DONE);
    end

    // Each lane handles one byte of the current group, groups taken in ascending order.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
`ifdef AES128_INV_ROUND_PAR4_EN
        assign lane_idx[l] = {cnt_q, 2'(l)};
`else
        assign lane_idx[l] = cnt_q;
`endif
        assign sbox_in[l] = work_q[4'd15 - lane_idx[l]];

        aes128_rijndael_inv_sbox u_inv_sbox (
            .in_byte  (sbox_in[l]),
            .out_byte (sbox_out[l])
        );
    end

    always_comb begin
        work_sub = work_q;
        for (int l = 0; l < LANES; l++) begin
            work_sub[4'd15 - lane_idx[l]] = sbox_out[l];
        end
    end

    always_comb begin
        mixed = work_q ^ key_q;
        if (!last_q) begin
            mixed = inv_mix_columns(mixed);
        end
    end

    // The counter wraps to zero naturally as the final group is written.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            work_q  <= '0;
            key_q   <= '0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
            state_o <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        work_q <= inv_shift_rows(state_i);
                        key_q  <= round_key_i;
                        last_q <= last_i;
                        cnt_q  <= '0;
                    end
                end
                SUB: begin
                    work_q <= work_sub;
                    cnt_q  <= cnt_q + CNT_W'(1);
                end
                MIX: begin
                    state_o <= mixed;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes128_inv_round.sv
// Self-checking bench for aes128_inv_round against a byte-matrix inverse-round model
// whose inverse S-box is derived from GF(2^8) inversion plus the affine map.
module tb_aes128_inv_round;

`ifdef AES128_INV_ROUND_PAR4_EN
    localparam int LAT   = 5;
    localparam int RST_K = 2;
`else
    localparam int LAT   = 17;
    localparam int RST_K = 8;
`endif

    localparam logic [127:0] S25 = 128'h6353e08c0960e104cd70b751bacad0e7;
    localparam logic [127:0] K25 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] E25 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] S26 = 128'h7ad5fda789ef4e272bca100b3d9ff59f;
    localparam logic [127:0] K26 = 128'h549932d1f08557681093ed9cbe2c974e;
    localparam logic [127:0] E26 = 128'h54d990a16ba09ab596bbf40ea111702f;
    localparam logic [127:0] E52 = {16{8'h52}};

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start_i = 1'b0;
    logic         last_i = 1'b0;
    logic [127:0] state_i = '0;
    logic [127:0] round_key_i = '0;
    logic [127:0] state_o;
    logic         busy_o;
    logic         done_o;

    int           tests = 0;
    int           fails = 0;
    logic [7:0]   inv_tab [256];

    int           phase = -1;
    logic [127:0] exp_out = '0;
    logic [127:0] pend = '0;
    bit           chk_en = 1'b0;

    always #5 clk = ~clk;

    aes128_inv_round dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .state_i     (state_i),
        .round_key_i (round_key_i),
        .last_i      (last_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .state_o     (state_o)
    );

    // Carry-less product then polynomial reduction by x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
        logic [14:0] prod;
        prod = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[3'(i)]) prod ^= 15'(a) << i;
        end
        for (int i = 14; i >= 8; i--) begin
            if (prod[4'(i)]) prod ^= 15'(9'h11b) << (i - 8);
        end
        return prod[7:0];
    endfunction

    function automatic void build_tables();
        logic [7:0] inv;
        logic [7:0] s;
        logic [7:0] cst;
        cst = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            if (x != 0) begin
                for (int y = 1; y < 256; y++) begin
                    if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
                end
            end
            for (int i = 0; i < 8; i++) begin
                s[3'(i)] = inv[3'(i)] ^ inv[3'(i + 4)] ^ inv[3'(i + 5)] ^ inv[3'(i + 6)]
                         ^ inv[3'(i + 7)] ^ cst[3'(i)];
            end
            inv_tab[s] = 8'(x);
        end
    endfunction

    function automatic logic [127:0] ref_round(logic [127:0] s, logic [127:0] k, logic l);
        logic [7:0]   a    [16];
        logic [7:0]   b    [16];
        logic [7:0]   m    [4];
        logic [7:0]   coef [4];
        logic [127:0] r;
        coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        for (int i = 0; i < 16; i++) a[i] = s[127 - 8 * i -: 8];
        for (int row = 0; row < 4; row++) begin
            for (int c = 0; c < 4; c++) begin
                b[row + 4 * c] = a[row + 4 * ((c - row + 4) % 4)];
            end
        end
        for (int i = 0; i < 16; i++) b[i] = inv_tab[b[i]] ^ k[127 - 8 * i -: 8];
        if (!l) begin
            for (int c = 0; c < 4; c++) begin
                for (int row = 0; row < 4; row++) begin
                    m[row] = 8'h00;
                    for (int j = 0; j < 4; j++) begin
                        m[row] ^= gmul(coef[(j - row + 4) % 4], b[j + 4 * c]);
                    end
                end
                for (int row = 0; row < 4; row++) b[row + 4 * c] = m[row];
            end
        end
        for (int i = 0; i < 16; i++) r[127 - 8 * i -: 8] = b[i];
        return r;
    endfunction

    function automatic logic [127:0] randState();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check(string name, logic [127:0] act, logic [127:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Transaction-level timing model: a round accepted in IDLE finishes LAT edges later.
    always @(posedge clk) begin
        if (!rst_n) begin
            phase   <= -1;
            exp_out <= '0;
        end else if (phase < 0) begin
            if (start_i) begin
                phase <= 0;
                pend  <= ref_round(state_i, round_key_i, last_i);
            end
        end else if (phase == LAT) begin
            phase <= -1;
        end else begin
            phase <= phase + 1;
            if (phase + 1 == LAT) exp_out <= pend;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cycle busy_o", 128'(busy_o), 128'(phase >= 0));
            check("cycle done_o", 128'(done_o), 128'(phase == LAT));
            check("cycle state_o", state_o, exp_out);
        end
    end

    task automatic applyStimulus(logic [127:0] s, logic [127:0] k, logic l);
        @(negedge clk);
        state_i     = s;
        round_key_i = k;
        last_i      = l;
        start_i     = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic checkOutput(string name, logic [127:0] req);
        check(name, state_o, req);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((busy_o !== 1'b0) && n < 4 * LAT) begin
            @(negedge clk);
            n++;
        end
        check("drain to idle", 128'(busy_o), 128'(0));
    endtask

    task automatic runRound(string name, logic [127:0] s, logic [127:0] k, logic l,
                            logic [127:0] req);
        int n;
        applyStimulus(s, k, l);
        n = 0;
        while (done_o !== 1'b1 && n < 4 * LAT) begin
            @(negedge clk);
            n++;
        end
        check({name, " latency"}, 128'(n), 128'(LAT));
        checkOutput({name, " result"}, req);
        @(negedge clk);
        check({name, " done one cycle"}, 128'(done_o), 128'(0));
    endtask

    task automatic heldStart();
        int t0, t1, t2, seen, n;
        t0 = 0; t1 = 0; t2 = 0; seen = 0; n = 0;
        @(negedge clk);
        start_i     = 1'b1;
        state_i     = randState();
        round_key_i = randState();
        last_i      = 1'($urandom_range(0, 1));
        while (seen < 3 && n < 10 * LAT) begin
            @(negedge clk);
            n++;
            if (done_o) begin
                if (seen == 0) t0 = n;
                else if (seen == 1) t1 = n;
                else t2 = n;
                seen++;
            end
            state_i     = randState();
            round_key_i = randState();
            last_i      = 1'($urandom_range(0, 1));
        end
        start_i = 1'b0;
        check("held start pulses", 128'(seen), 128'(3));
        check("held start spacing 1", 128'(t1 - t0), 128'(LAT + 2));
        check("held start spacing 2", 128'(t2 - t1), 128'(LAT + 2));
        drain();
    endtask

    task automatic resetMid();
        applyStimulus(randState(), randState(), 1'b0);
        repeat (RST_K) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid reset busy_o", 128'(busy_o), 128'(0));
        check("mid reset done_o", 128'(done_o), 128'(0));
        check("mid reset state_o", state_o, 128'(0));
        rst_n = 1'b1;
        runRound("after reset", S26, K26, 1'b0, E26);
    endtask

    task automatic sweep();
        int seen, n;
        seen = 0; n = 0;
        @(negedge clk);
        start_i = 1'b1;
        while (seen < 100 && n < 100 * (LAT + 2) + 50) begin
            state_i     = randState();
            round_key_i = randState();
            last_i      = 1'($urandom_range(0, 1));
            @(negedge clk);
            n++;
            if (done_o) seen++;
        end
        start_i = 1'b0;
        check("sweep round count", 128'(seen), 128'(100));
        drain();
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        build_tables();
        check("model inv_sbox 63", 128'(inv_tab[8'h63]), 128'(8'h00));
        check("model inv_sbox 00", 128'(inv_tab[8'h00]), 128'(8'h52));
        check("model final round", ref_round(S25, K25, 1'b1), E25);
        check("model middle round", ref_round(S26, K26, 1'b0), E26);
        check("model zero round", ref_round('0, '0, 1'b0), E52);

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("reset busy_o", 128'(busy_o), 128'(0));
        check("reset done_o", 128'(done_o), 128'(0));
        check("reset state_o", state_o, 128'(0));
        rst_n = 1'b1;

        runRound("final round", S25, K25, 1'b1, E25);
        runRound("middle round", S26, K26, 1'b0, E26);
        runRound("zero last0", '0, '0, 1'b0, E52);
        runRound("zero last1", '0, '0, 1'b1, E52);
        heldStart();
        resetMid();
        sweep();

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
